// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: four-phase req/ack slave for word loads and stores,
// with a fixed number of wait states and an error response for bad addresses.
// Optional LED register at LED_ADDR when DMEM_LED_MMIO_EN is defined.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] LED_ADDR    = 32'h0000_0100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic        err_o,
  output logic [31:0] rdata_o
`ifdef DMEM_LED_MMIO_EN
  ,
  output logic [7:0]  leds_o
`endif
);

  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
  localparam logic [7:0]  WaitInit = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           mem_q [Depth];

  logic [ADDR_WIDTH-1:0] idx;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  is_led;
  logic                  access_err;
  logic                  complete;
  logic                  mem_we;

  assign idx          = addr_i[ADDR_WIDTH+1:2];
  assign misaligned   = |addr_i[1:0];
  assign out_of_range = |addr_i[31:ADDR_WIDTH+2];

`ifdef DMEM_LED_MMIO_EN
  logic [7:0] leds_q, leds_d;
  assign is_led = (addr_i == LED_ADDR);
`else
  // Without the LED register its address is just another out-of-range address.
  logic unused_led_addr;
  assign unused_led_addr = ^LED_ADDR;
  assign is_led          = 1'b0;
`endif

  assign access_err = misaligned | (out_of_range & ~is_led);
  // The access happens on the edge where the wait count has run out and req is still high.
  assign complete   = (state_q == StWait) & req_i & (cnt_q == 8'd0);
  assign mem_we     = complete & we_i & ~access_err & ~is_led;

  // Next-state and response logic for the handshake FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (req_i) begin
          state_d = StWait;
          cnt_d   = WaitInit;
        end
      end
      StWait: begin
        if (!req_i) begin
          state_d = StIdle;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = StAck;
          ack_d   = 1'b1;
          err_d   = access_err;
          if (access_err || we_i) begin
            rdata_d = 32'd0;
`ifdef DMEM_LED_MMIO_EN
          end else if (is_led) begin
            rdata_d = {24'd0, leds_q};
`endif
          end else begin
            rdata_d = mem_q[idx];
          end
        end
      end
      StAck: begin
        if (!req_i) begin
          state_d = StIdle;
          ack_d   = 1'b0;
          err_d   = 1'b0;
          rdata_d = 32'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Word RAM; contents survive reset. mem_we is low whenever the FSM is held in reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[idx] <= wdata_i;
    end
  end

`ifdef DMEM_LED_MMIO_EN
  // LED register update on a completing store to LED_ADDR.
  always_comb begin
    leds_d = leds_q;
    if (complete && we_i && is_led) begin
      leds_d = wdata_i[7:0];
    end
  end

  // LED register state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      leds_q <= 8'd0;
    end else begin
      leds_q <= leds_d;
    end
  end

  assign leds_o = leds_q;
`endif

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance with two wait states, one with none.
// Expected responses are queued when a request is driven and compared when ack arrives.
module tb_dmem_responder;

  localparam int unsigned Wait0   = 2;
  localparam int unsigned Wait1   = 0;
  localparam logic [31:0] LedAddr = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        req0, we0, ack0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        req1, we1, ack1, err1;
  logic [31:0] addr1, wdata1, rdata1;
`ifdef DMEM_LED_MMIO_EN
  logic [7:0]  leds0, leds1;
`endif

  dmem_responder #(.ADDR_WIDTH(4), .WAIT_CYCLES(Wait0), .LED_ADDR(LedAddr)) u_dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req0),
    .we_i    (we0),
    .addr_i  (addr0),
    .wdata_i (wdata0),
    .ack_o   (ack0),
    .err_o   (err0),
    .rdata_o (rdata0)
`ifdef DMEM_LED_MMIO_EN
    ,
    .leds_o  (leds0)
`endif
  );

  dmem_responder #(.ADDR_WIDTH(4), .WAIT_CYCLES(Wait1), .LED_ADDR(LedAddr)) u_dut_w0 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req1),
    .we_i    (we1),
    .addr_i  (addr1),
    .wdata_i (wdata1),
    .ack_o   (ack1),
    .err_o   (err1),
    .rdata_o (rdata1)
`ifdef DMEM_LED_MMIO_EN
    ,
    .leds_o  (leds1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic sel    = 1'b0;

  logic        ack_m, err_m;
  logic [31:0] rdata_m;
  assign ack_m   = sel ? ack1 : ack0;
  assign err_m   = sel ? err1 : err0;
  assign rdata_m = sel ? rdata1 : rdata0;

`ifdef DMEM_LED_MMIO_EN
  localparam logic        LedErr   = 1'b0;
  localparam logic [31:0] LedRdata = 32'h0000_00C3;
`else
  localparam logic        LedErr   = 1'b1;
  localparam logic [31:0] LedRdata = 32'h0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    if (s) begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  // Full four-phase transaction with latency, hold and release checks.
  task automatic access(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic e_err, input logic [31:0] e_rd);
    int   lat;
    exp_t ex;
    sel = s;
    sb.push_back({e_err, e_rd});
    @(negedge clk);
    drive(s, 1'b1, w, a, d);
    lat = 0;
    // First posedge after raising req is the sampling edge t; ack must be visible after
    // edge t+1+WAIT, i.e. after the (WAIT+2)-th edge counted from t.
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ack_m && lat < 64);
    ex = sb.pop_front();
    chk("ack_rise", {31'd0, ack_m}, 32'd1);
    chk("latency", lat, (s ? Wait1 : Wait0) + 2);
    chk("err", {31'd0, err_m}, {31'd0, ex.err});
    chk("rdata", rdata_m, ex.rdata);
    @(posedge clk);
    #1;
    chk("ack_hold", {31'd0, ack_m}, 32'd1);
    chk("rdata_hold", rdata_m, ex.rdata);
    @(negedge clk);
    drive(s, 1'b0, w, a, d);
    @(posedge clk);
    #1;
    chk("ack_fall", {31'd0, ack_m}, 32'd0);
    chk("err_clear", {31'd0, err_m}, 32'd0);
    chk("rdata_clear", rdata_m, 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int acks;

    vecs.push_back({1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, 32'h0});
    vecs.push_back({1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'hDEAD_BEEF});
    vecs.push_back({1'b1, 32'h0000_0000, 32'h55AA_55AA, 1'b0, 32'h0});
    vecs.push_back({1'b1, 32'h0000_0004, 32'h1111_2222, 1'b0, 32'h0});
    vecs.push_back({1'b1, 32'h0000_0006, 32'hFFFF_FFFF, 1'b1, 32'h0});
    vecs.push_back({1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h1111_2222});
    vecs.push_back({1'b1, 32'h0000_0040, 32'h9999_9999, 1'b1, 32'h0});
    vecs.push_back({1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'h0});
    vecs.push_back({1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h55AA_55AA});
    vecs.push_back({1'b0, 32'h0000_0001, 32'h0,         1'b1, 32'h0});
    vecs.push_back({1'b1, 32'h0000_003C, 32'hCAFE_F00D, 1'b0, 32'h0});
    vecs.push_back({1'b0, 32'h0000_003C, 32'h0,         1'b0, 32'hCAFE_F00D});
    vecs.push_back({1'b1, 32'h0000_000C, 32'h0BAD_C0DE, 1'b0, 32'h0});
    vecs.push_back({1'b1, 32'h0000_0014, 32'h7777_8888, 1'b0, 32'h0});
    vecs.push_back({1'b1, 32'h0000_0008, 32'h0102_0304, 1'b0, 32'h0});
    vecs.push_back({1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h0102_0304});
    vecs.push_back({1'b1, LedAddr,       32'h0000_01C3, LedErr, 32'h0});
    vecs.push_back({1'b0, LedAddr,       32'h0,         LedErr, LedRdata});

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #12;
    chk("rst_ack", {31'd0, ack0}, 32'd0);
    chk("rst_err", {31'd0, err0}, 32'd0);
    chk("rst_rdata", rdata0, 32'd0);
    chk("rst_ack_w0", {31'd0, ack1}, 32'd0);
`ifdef DMEM_LED_MMIO_EN
    chk("rst_leds", {24'd0, leds0}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      access(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].err, vecs[i].rdata);
    end
`ifdef DMEM_LED_MMIO_EN
    chk("leds", {24'd0, leds0}, 32'h0000_00C3);
`endif

    // Zero wait states.
    access(1'b1, 1'b1, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0);
    access(1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678);

    // Abort: drop req mid-wait; no ack and no write.
    sel = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_000C, 32'hA5A5_A5A5);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_000C, 32'hA5A5_A5A5);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (ack0) acks++;
    end
    chk("abort_no_ack", acks, 32'd0);
    access(1'b0, 1'b0, 32'h0000_000C, 32'h0, 1'b0, 32'h0BAD_C0DE);

    // Reset during the wait of a store: store discarded, RAM otherwise intact.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0014, 32'hA5A5_A5A5);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_wait_ack", {31'd0, ack0}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 1'b0, 32'h0000_0014, 32'h0, 1'b0, 32'h7777_8888);
    access(1'b0, 1'b0, 32'h0000_0008, 32'h0, 1'b0, 32'h0102_0304);

    // Reset while acked: outputs clear asynchronously.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_003C, 32'h0);
    acks = 0;
    while (!ack0 && acks < 64) begin
      @(posedge clk);
      #1;
      acks++;
    end
    chk("pre_rst_rdata", rdata0, 32'hCAFE_F00D);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ack_async", {31'd0, ack0}, 32'd0);
    chk("rst_rdata_async", rdata0, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    access(1'b0, 1'b0, 32'h0000_003C, 32'h0, 1'b0, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
